// File: rtl/shift_word_deserializer.sv
// ---------------------------------------------------------------------------
// shift_word_deserializer
//
// Serial-in / parallel-out receiver for the Q3 stream of the 4-bit
// parallel-access shift register. Bits arrive MSB first, one per rising CP
// edge while SE is high. A word starts with START=1 (qualified by SE). Each
// finished word is placed in a holding register Q with a VALID/ACK handshake.
//
// Optional feature (macro DESER_PARITY_EN):
//   defined   - an even-parity bit follows the LENGTH data bits. Completion
//               happens on the parity-bit edge. PERR reports a parity error
//               for the word on Q.
//   undefined - words are LENGTH bits wide and PERR is constant 0.
//
// Parameters:
//   LENGTH     data bits per word (>= 2)
//
// Ports:
//   CP         clock, rising-edge active
//   MR         master reset, asynchronous, active-low
//   SI         serial data in, MSB first
//   SE         shift enable; SI/START are sampled only on edges with SE=1
//   START      start-of-word marker (qualified by SE)
//   ACK        consumer acknowledge of the word on Q
//   Q          last completed word
//   VALID      Q holds an unacknowledged word
//   BUSY       word reception in progress (state SHIFT)
//   OVR        sticky overrun flag, cleared only by MR
//   PERR       parity error of the word on Q (0 without DESER_PARITY_EN)
//   state_dbg  current FSM state (0 = IDLE, 1 = SHIFT) for observation
//
// Handshake (VALID/ACK): VALID rises on the completing edge and stays high
// until an edge with ACK=1. ACK while VALID=0 does nothing. A completion
// while VALID=1 and ACK=0 overwrites Q and sets OVR. A completion together
// with ACK=1 hands the old word off, so the new word is loaded cleanly
// without setting OVR. Q keeps its value after ACK.
// ---------------------------------------------------------------------------
module shift_word_deserializer #(
   parameter int LENGTH = 4
) (
   input  logic              CP,
   input  logic              MR,
   input  logic              SI,
   input  logic              SE,
   input  logic              START,
   input  logic              ACK,
   output logic [LENGTH-1:0] Q,
   output logic              VALID,
   output logic              BUSY,
   output logic              OVR,
   output logic              PERR,
   output logic              state_dbg
);

`ifdef DESER_PARITY_EN
   localparam int NBITS = LENGTH + 1;
`else
   localparam int NBITS = LENGTH;
`endif

   // The counter is sized for LENGTH+1 bits, plus headroom, so it never wraps.
   localparam int CW = $clog2(LENGTH + 2);
   localparam logic [CW-1:0] LAST_CNT = CW'(NBITS);
   localparam logic [CW-1:0] ONE_CNT  = CW'(1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [NBITS-1:0]  shreg_q, shreg_d;
   logic [CW-1:0]     count_q, count_d;
   logic [LENGTH-1:0] q_q, q_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              ovr_q, ovr_d;
   logic              perr_q, perr_d;

   // The shift register value that includes this edge's SI.
   logic [NBITS-1:0]  shifted;
   logic [CW-1:0]     count_inc;
   logic [LENGTH-1:0] word_data;
   logic              word_perr;

   always_comb begin
      shifted   = {shreg_q[NBITS-2:0], SI};
      count_inc = count_q + ONE_CNT;
`ifdef DESER_PARITY_EN
      // The parity bit is the last bit received, so it sits at the LSB.
      // The data bits sit above it. Even parity means the XOR over the
      // data bits and the parity bit is 0.
      word_data = shifted[NBITS-1:1];
      word_perr = ^shifted;
`else
      word_data = shifted;
      word_perr = 1'b0;
`endif
   end

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      count_d = count_q;
      q_d     = q_q;
      valid_d = valid_q & ~ACK;
      ovr_d   = ovr_q;
      perr_d  = perr_q;

      if (SE) begin
         if (START) begin
            // Start, or restart from SHIFT. Any partial word is dropped.
            // This check comes before completion, so a restart wins.
            state_d = SHIFT;
            shreg_d = {{(NBITS-1){1'b0}}, SI};
            count_d = ONE_CNT;
         end else if (state_q == SHIFT) begin
            if (count_inc == LAST_CNT) begin
               q_d     = word_data;
               perr_d  = word_perr;
               valid_d = 1'b1;
               if (valid_q && !ACK) begin
                  ovr_d = 1'b1;
               end
               state_d = IDLE;
               shreg_d = '0;
               count_d = '0;
            end else begin
               shreg_d = shifted;
               count_d = count_inc;
            end
         end
      end

      busy_d = (state_d == SHIFT);
   end

   always_ff @(posedge CP or negedge MR) begin
      if (!MR) begin
         state_q <= IDLE;
         shreg_q <= '0;
         count_q <= '0;
         q_q     <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         ovr_q   <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         count_q <= count_d;
         q_q     <= q_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         ovr_q   <= ovr_d;
         perr_q  <= perr_d;
      end
   end

   assign Q         = q_q;
   assign VALID     = valid_q;
   assign BUSY      = busy_q;
   assign OVR       = ovr_q;
   assign PERR      = perr_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_shift_word_deserializer.sv
// ---------------------------------------------------------------------------
// tb_shift_word_deserializer
//
// Directed bench for shift_word_deserializer with LENGTH=4. Inputs change on
// the falling edge of CP. Outputs are sampled 1 time unit after the rising
// edge. Expected words are pushed into exp_q and popped at each check.
// Without DESER_PARITY_EN only the LENGTH data bits are sent. With it, an
// even-parity bit follows each word.
// ---------------------------------------------------------------------------
module tb_shift_word_deserializer;

   localparam int LENGTH = 4;

   logic              CP    = 1'b0;
   logic              MR    = 1'b0;
   logic              SI    = 1'b0;
   logic              SE    = 1'b0;
   logic              START = 1'b0;
   logic              ACK   = 1'b0;
   logic [LENGTH-1:0] Q;
   logic              VALID;
   logic              BUSY;
   logic              OVR;
   logic              PERR;
   logic              state_dbg;

   int checks = 0;
   int errors = 0;
   logic [LENGTH-1:0] exp_q[$];

   shift_word_deserializer #(.LENGTH(LENGTH)) dut (
      .CP        (CP),
      .MR        (MR),
      .SI        (SI),
      .SE        (SE),
      .START     (START),
      .ACK       (ACK),
      .Q         (Q),
      .VALID     (VALID),
      .BUSY      (BUSY),
      .OVR       (OVR),
      .PERR      (PERR),
      .state_dbg (state_dbg)
   );

   // ---------------- clock ----------------
   always #5 CP = ~CP;

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pops the next expected word and checks Q against it.
   task automatic check_word(input string tag);
      logic [LENGTH-1:0] exp_w;
      exp_w = exp_q.pop_front();
      check(tag, Q, exp_w);
   endtask

   // ---------------- drivers ----------------
   // Drives one CP cycle. After it returns, the rising edge has passed by 1 unit.
   task automatic step(input logic se, input logic st, input logic si, input logic ack);
      @(negedge CP);
      SE    = se;
      START = st;
      SI    = si;
      ACK   = ack;
      @(posedge CP);
      #1;
   endtask

   // Sends a full word, MSB first. With parity enabled, the even-parity bit
   // follows. ack_last raises ACK on the completing edge only.
   task automatic send_word(input logic [LENGTH-1:0] w, input logic ack_last);
      for (int i = LENGTH - 1; i >= 0; i--) begin
`ifdef DESER_PARITY_EN
         step(1'b1, (i == LENGTH - 1), w[i], 1'b0);
`else
         step(1'b1, (i == LENGTH - 1), w[i], (i == 0) && ack_last);
`endif
      end
`ifdef DESER_PARITY_EN
      step(1'b1, 1'b0, ^w, ack_last);
`endif
      @(negedge CP);
      SE  = 1'b0;
      ACK = 1'b0;
   endtask

   // Sends the last data bit. With parity enabled, it then sends the parity bit.
   task automatic finish_word(input logic last_bit, input logic par_bit);
      step(1'b1, 1'b0, last_bit, 1'b0);
`ifdef DESER_PARITY_EN
      check("busy_before_parity", BUSY, 1'b1);
      step(1'b1, 1'b0, par_bit, 1'b0);
`endif
   endtask

   task automatic pulse_reset();
      @(negedge CP);
      SE = 1'b0; START = 1'b0; ACK = 1'b0;
      MR = 1'b0;
      #1;
   endtask

   task automatic release_reset();
      @(negedge CP);
      MR = 1'b1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      // Reset state.
      #12;
      check("rst_q", Q, 4'b0000);
      check("rst_valid", VALID, 1'b0);
      check("rst_busy", BUSY, 1'b0);
      check("rst_ovr", OVR, 1'b0);
      check("rst_perr", PERR, 1'b0);
      release_reset();

      // Basic receive: 1011.
      exp_q.push_back(4'b1011);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      check("basic_busy1", BUSY, 1'b1);
      check("basic_state1", state_dbg, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("basic_busy2", BUSY, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      check("basic_busy3", BUSY, 1'b1);
      check("basic_valid_early", VALID, 1'b0);
      finish_word(1'b1, 1'b1);
      check_word("basic_q");
      check("basic_valid", VALID, 1'b1);
      check("basic_busy_done", BUSY, 1'b0);
      check("basic_perr", PERR, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("basic_ack_valid", VALID, 1'b0);
      check("basic_ack_q_hold", Q, 4'b1011);

      // SI in IDLE without START is ignored. ACK with VALID=0 does nothing.
      step(1'b1, 1'b0, 1'b1, 1'b1);
      check("idle_si_busy", BUSY, 1'b0);
      check("idle_ack_valid", VALID, 1'b0);

      // SE gap between bits 2 and 3. START with SE=0 is ignored: 1001.
      exp_q.push_back(4'b1001);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      check("gap_busy", BUSY, 1'b1);
      check("gap_valid", VALID, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      finish_word(1'b1, 1'b0);
      check_word("gap_q");
      check("gap_valid_done", VALID, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);

      // Restart after two bits (1,1), then the word 0110.
      exp_q.push_back(4'b0110);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      check("restart_no_early_valid", VALID, 1'b0);
      check("restart_q_hold", Q, 4'b1001);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      check("restart_busy", BUSY, 1'b1);
      finish_word(1'b0, 1'b0);
      check_word("restart_q");
      check("restart_valid", VALID, 1'b1);

      // Reset in the middle of a word, with a word still pending on Q.
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      pulse_reset();
      check("midrst_q", Q, 4'b0000);
      check("midrst_valid", VALID, 1'b0);
      check("midrst_busy", BUSY, 1'b0);
      check("midrst_ovr", OVR, 1'b0);
      release_reset();
      exp_q.push_back(4'b1010);
      send_word(4'b1010, 1'b0);
      check_word("midrst_next_q");
      check("midrst_next_valid", VALID, 1'b1);
      check("midrst_next_ovr", OVR, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);

      // Overrun: 0001 left unacknowledged, then 1110.
      exp_q.push_back(4'b0001);
      send_word(4'b0001, 1'b0);
      check_word("ovr_first_q");
      check("ovr_first_ovr", OVR, 1'b0);
      exp_q.push_back(4'b1110);
      send_word(4'b1110, 1'b0);
      check_word("ovr_second_q");
      check("ovr_valid", VALID, 1'b1);
      check("ovr_flag", OVR, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("ovr_ack_valid", VALID, 1'b0);
      check("ovr_sticky", OVR, 1'b1);
      pulse_reset();
      check("ovr_cleared_by_mr", OVR, 1'b0);
      release_reset();

      // Completion with ACK on the same edge as a pending word.
      exp_q.push_back(4'b0101);
      send_word(4'b0101, 1'b0);
      check_word("simack_first_q");
      exp_q.push_back(4'b0011);
      send_word(4'b0011, 1'b1);
      check_word("simack_q");
      check("simack_valid", VALID, 1'b1);
      check("simack_ovr", OVR, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("simack_ack_valid", VALID, 1'b0);

`ifdef DESER_PARITY_EN
      // Parity: 1011 + 1 is even parity (ok). 1011 + 0 is a parity error.
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      finish_word(1'b1, 1'b1);
      check("par_ok_q", Q, 4'b1011);
      check("par_ok_perr", PERR, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      finish_word(1'b1, 1'b0);
      check("par_bad_q", Q, 4'b1011);
      check("par_bad_perr", PERR, 1'b1);
`else
      check("noparity_perr", PERR, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
